// File: rtl/mult_seq_controller.sv
// mult_seq_controller: run sequencer for the multiplier test harness.
//
// After an accepted start it issues one operand read per cycle for N
// vectors, then replays every read as a result write exactly L_eff
// cycles later through a flushable, tap-selected delay line.
//
// Optional feature: define MULT_SEQ_CYCLE_COUNT_EN to build the saturating
// run cycle counter. When the macro is undefined, cycle_count is tied to 0.
//
// Handshake: there is no backpressure. start and abort are single-cycle
// requests sampled on the rising edge of pll_clock. abort beats start.
// r_en/r_addr and we/w_addr are fire-and-forget strobes: one transfer
// happens in every cycle where the enable is high.
module mult_seq_controller #(
  parameter int ADDR_WIDTH  = 9,
  parameter int MAX_LATENCY = 16,
  localparam int LAT_WIDTH  = $clog2(MAX_LATENCY + 1)
) (
  input  logic                  pll_clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   num_vectors,
  input  logic [LAT_WIDTH-1:0]  latency,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycle_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   N_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LAT_WIDTH-1:0]  LAT_ONE  = LAT_WIDTH'(1);
  localparam logic [LAT_WIDTH-1:0]  LAT_MAX  = LAT_WIDTH'(MAX_LATENCY);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   reads_left_q, reads_left_d;
  logic [LAT_WIDTH-1:0]  l_eff_q, l_eff_d;
  logic [LAT_WIDTH-1:0]  drain_left_q, drain_left_d;
  logic                  r_en_q, r_en_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  // Stage j holds the read strobe delayed by j cycles (stage 0 mirrors r_en).
  logic                  dl_v_q [MAX_LATENCY];
  logic                  dl_v_d [MAX_LATENCY];
  logic [ADDR_WIDTH-1:0] dl_a_q [MAX_LATENCY];
  logic [ADDR_WIDTH-1:0] dl_a_d [MAX_LATENCY];

  logic                  start_ok;
  logic [LAT_WIDTH-1:0]  lat_clamped;

  assign start_ok = (state_q == S_IDLE) && start && !abort;

  // Clamp the requested latency into 1..MAX_LATENCY.
  always_comb begin
    lat_clamped = latency;
    if (latency == '0) begin
      lat_clamped = LAT_ONE;
    end else if (latency > LAT_MAX) begin
      lat_clamped = LAT_MAX;
    end
  end

  // State register.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && (num_vectors != '0)) state_d = S_ISSUE;
        S_ISSUE: if (reads_left_q == N_ONE)        state_d = S_DRAIN;
        S_DRAIN: if (drain_left_q == LAT_ONE)      state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values: read issue, delay line, status.
  always_comb begin
    reads_left_d = reads_left_q;
    l_eff_d      = l_eff_q;
    drain_left_d = drain_left_q;
    r_en_d       = 1'b0;
    r_addr_d     = r_addr_q;
    done_d       = done_q;
    busy_d       = (state_d != S_IDLE);
    we_d         = 1'b0;
    w_addr_d     = w_addr_q;

    if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_vectors == '0) begin
              done_d = 1'b1;
            end else begin
              done_d       = 1'b0;
              l_eff_d      = lat_clamped;
              reads_left_d = num_vectors;
              r_en_d       = 1'b1;
              r_addr_d     = '0;
            end
          end
        end
        S_ISSUE: begin
          reads_left_d = reads_left_q - N_ONE;
          if (reads_left_q == N_ONE) begin
            drain_left_d = l_eff_q;
          end else begin
            r_en_d   = 1'b1;
            r_addr_d = r_addr_q + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          drain_left_d = drain_left_q - LAT_ONE;
          if (drain_left_q == LAT_ONE) begin
            done_d = 1'b1;
          end
        end
        default: ;
      endcase

      // Write strobe is the tap L_eff-1 of the line, registered once more.
      for (int i = 0; i < MAX_LATENCY; i++) begin
        if (l_eff_q == LAT_WIDTH'(i + 1)) begin
          we_d     = dl_v_q[i];
          w_addr_d = dl_a_q[i];
        end
      end
    end

    // Shift the line; abort and any accepted start clear it so residue from
    // a shorter-latency run can never reach a deeper tap.
    dl_v_d[0] = r_en_d;
    dl_a_d[0] = r_addr_d;
    for (int i = 1; i < MAX_LATENCY; i++) begin
      dl_v_d[i] = (abort || start_ok) ? 1'b0 : dl_v_q[i-1];
      dl_a_d[i] = dl_a_q[i-1];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      reads_left_q <= '0;
      l_eff_q      <= LAT_ONE;
      drain_left_q <= '0;
      r_en_q       <= 1'b0;
      r_addr_q     <= '0;
      we_q         <= 1'b0;
      w_addr_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < MAX_LATENCY; i++) begin
        dl_v_q[i] <= 1'b0;
        dl_a_q[i] <= '0;
      end
    end else begin
      reads_left_q <= reads_left_d;
      l_eff_q      <= l_eff_d;
      drain_left_q <= drain_left_d;
      r_en_q       <= r_en_d;
      r_addr_q     <= r_addr_d;
      we_q         <= we_d;
      w_addr_q     <= w_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int i = 0; i < MAX_LATENCY; i++) begin
        dl_v_q[i] <= dl_v_d[i];
        dl_a_q[i] <= dl_a_d[i];
      end
    end
  end

`ifdef MULT_SEQ_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Busy-cycle counter: cleared on accepted start, saturating, held when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (busy_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

  assign r_en      = r_en_q;
  assign r_addr    = r_addr_q;
  assign we        = we_q;
  assign w_addr    = w_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_seq_controller.sv
// Bench for mult_seq_controller: per-cycle reference timeline derived from
// N and L_eff, plus a write-address scoreboard.
module tb_mult_seq_controller;

  localparam int AW = 9;
  localparam int ML = 16;
  localparam int LW = $clog2(ML + 1);

  logic          pll_clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   num_vectors = '0;
  logic [LW-1:0] latency = '0;
  logic          r_en, we, busy, done;
  logic [AW-1:0] r_addr, w_addr;
  logic [31:0]   cycle_count;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;
  logic [AW-1:0] exp_q[$];

  mult_seq_controller #(.ADDR_WIDTH(AW), .MAX_LATENCY(ML)) dut (
    .pll_clock   (pll_clock),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .num_vectors (num_vectors),
    .latency     (latency),
    .r_en        (r_en),
    .r_addr      (r_addr),
    .we          (we),
    .w_addr      (w_addr),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count),
    .dbg_state   (dbg_state)
  );

  // Clock.
  always #5 pll_clock = ~pll_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, tcyc, obs, exp);
    end
  endtask

  function automatic int leff(input int l);
    if (l == 0) return 1;
    if (l > ML) return ML;
    return l;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_r_en"}, 32'(r_en), 32'd0);
    check({tag, "_r_addr"}, 32'(r_addr), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_count"}, cycle_count, 32'd0);
  endtask

  // Launch a run at the current negedge and check every following cycle.
  // abort_at / glitch_at are cycle offsets from acceptance (0 = none).
  task automatic run_case(input int n, input int lat, input int abort_at,
                          input int glitch_at, input int tail);
    int le, run_len, busy_end, c_end, exp_cnt;
    bit live, exp_ren, exp_we, exp_busy, exp_done;
    logic [AW-1:0] wa;
    le       = leff(lat);
    run_len  = (n == 0) ? 0 : n + le;
    busy_end = (abort_at > 0) ? abort_at : run_len;
    c_end    = (abort_at > 0) ? abort_at + 1 + tail : run_len + 1 + tail;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(AW'(k));
    start       = 1'b1;
    abort       = 1'b0;
    num_vectors = (AW + 1)'(n);
    latency     = LW'(lat);
    @(negedge pll_clock);
    start = 1'b0;
    for (int c = 1; c <= c_end; c++) begin
      tcyc     = c;
      live     = (abort_at == 0) || (c <= abort_at);
      exp_ren  = live && (c <= n);
      exp_we   = live && (c > le) && (c <= n + le);
      exp_busy = (c <= busy_end);
      exp_done = (abort_at == 0) && (c > run_len);
`ifdef MULT_SEQ_CYCLE_COUNT_EN
      exp_cnt = (c - 1 < busy_end) ? c - 1 : busy_end;
`else
      exp_cnt = 0;
`endif
      check("r_en", 32'(r_en), 32'(exp_ren));
      if (exp_ren) check("r_addr", 32'(r_addr), 32'((c - 1) % (1 << AW)));
      check("we", 32'(we), 32'(exp_we));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("count", cycle_count, 32'(exp_cnt));
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("w_unexpected", 32'(we), 32'd0);
        end else begin
          wa = exp_q.pop_front();
          check("w_addr", 32'(w_addr), 32'(wa));
        end
      end
      if (c == abort_at) abort = 1'b1;
      if (c == glitch_at) begin
        start       = 1'b1;
        num_vectors = (AW + 1)'($urandom_range(1, 20));
        latency     = LW'($urandom_range(0, 31));
      end
      if (c < c_end) begin
        @(negedge pll_clock);
        abort = 1'b0;
        start = 1'b0;
      end
    end
    if (abort_at == 0) check("w_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Asynchronous reset in the middle of an N=8 run.
  task automatic reset_mid_run();
    start       = 1'b1;
    num_vectors = (AW + 1)'(8);
    latency     = LW'(2);
    @(negedge pll_clock);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tcyc = c;
      check("rst_run_r_en", 32'(r_en), 32'd1);
      check("rst_run_r_addr", 32'(r_addr), 32'(c - 1));
      if (c < 5) @(negedge pll_clock);
    end
    resetn = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge pll_clock);
    check_all_zero("rst_held");
    resetn = 1'b1;
    @(negedge pll_clock);
    @(negedge pll_clock);
    check_all_zero("rst_after");
  endtask

  initial begin
    int n, lat, le, ab, gl;
    resetn = 1'b0;
    repeat (3) @(negedge pll_clock);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge pll_clock);
    check_all_zero("idle");

    run_case(4, 3, 0, 0, 2);
    run_case(0, 5, 0, 0, 1);
    run_case(512, 16, 0, 0, 1);
    run_case(3, 0, 0, 0, 0);
    run_case(3, 31, 0, 0, 1);
    run_case(10, 5, 6, 0, 1);
    run_case(2, 4, 0, 0, 2);
    run_case(8, 2, 0, 3, 2);

    // Simultaneous start and abort in IDLE: abort wins, done is retained.
    start       = 1'b1;
    abort       = 1'b1;
    num_vectors = (AW + 1)'(5);
    latency     = LW'(2);
    @(negedge pll_clock);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_r_en", 32'(r_en), 32'd0);
    check("sa_done", 32'(done), 32'd1);
    @(negedge pll_clock);
    check("sa_busy2", 32'(busy), 32'd0);

    reset_mid_run();

    for (int r = 0; r < 16; r++) begin
      n   = $urandom_range(0, 40);
      lat = $urandom_range(0, 31);
      le  = leff(lat);
      ab  = 0;
      gl  = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n + le);
      else if (n > 0 && $urandom_range(0, 1) == 1) gl = $urandom_range(1, n + le);
      run_case(n, lat, ab, gl, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_controller.md
# mult_seq_controller

Run sequencer for the multiplier test harness, clocked in the PLL domain. After a start command it issues one operand-RAM read per cycle over a programmable number of vectors. It then replays each read address as a result-RAM write address and write enable after a programmable pipeline latency. It reports busy/done status and, optionally, a run cycle count. It replaces hand-chained fixed delay stages with one runtime-configurable, flushable delay line.

## Interface
- ADDR_WIDTH, 9, operand/result RAM address width
- MAX_LATENCY, 16, deepest supported read-to-write latency in cycles (≥1)
- LAT_WIDTH, $clog2(MAX_LATENCY+1), derived width of `latency` (not overridden)

Ports:
- pll_clock  in  1  sole clock; all logic rising-edge
- resetn  in  1  reset, asynchronous and active-low
- start  in  1  single-cycle run request; honoured only in IDLE
- abort  in  1  single-cycle cancel; honoured in any state
- num_vectors  in  ADDR_WIDTH+1  vectors per run, 0..2^ADDR_WIDTH; sampled on accepted start
- latency  in  LAT_WIDTH  read-to-write delay L; sampled on accepted start
- r_en  out  1  operand read strobe
- r_addr  out  ADDR_WIDTH  operand read address
- we  out  1  result write enable
- w_addr  out  ADDR_WIDTH  result write address
- busy  out  1  run in progress
- done  out  1  sticky run-complete flag
- cycle_count  out  32  cycles spent busy in the last/current run

## Operation
- Reset value of every output is 0. Reset puts the FSM in IDLE and clears the delay line. Reset mid-run drops all strobes asynchronously; no partial state survives.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE: on `start` with sampled N>0 and no `abort`.
  - Latch N and L_eff, the sampled latency clamped into 1..MAX_LATENCY (0→1, >MAX→MAX).
  - Clear `done`; load `r_addr`=0.
- IDLE with `start` and N=0: set `done` next cycle; FSM stays IDLE; no strobes issued.
- ISSUE behaviour:
  - `r_en`=1 every cycle.
  - `r_addr` increments by 1 per cycle, wrapping modulo 2^ADDR_WIDTH; N=2^ADDR_WIDTH covers every address exactly once.
  - After the N-th read, go to DRAIN.
- DRAIN: `r_en`=0. When the final write has been issued, go to IDLE and set `done`.
- Delay line: MAX_LATENCY stages of {valid, addr}, with a tap selected by L_eff. `we`/`w_addr` equal `r_en`/`r_addr` delayed exactly L_eff cycles.
- `abort`, any state:
  - Next cycle: FSM to IDLE; `r_en`, `we` and `busy` go to 0; delay line flushed.
  - `done` is not set.
  - Abort wins over a simultaneous `start`.
- `start` during ISSUE/DRAIN is ignored, with no effect on the latched N and L.
- `busy` = 1 in ISSUE and DRAIN.

## Timing
- `start` is accepted at edge T. First `r_en` (addr 0) is visible in cycle T+1; read k occurs in cycle T+1+k; last read is in T+N.
- Write k occurs in cycle T+1+k+L_eff, i.e. `we` is high for exactly N consecutive cycles.
- `busy` is high for cycles T+1 through T+N+L_eff. `done` rises in cycle T+N+L_eff+1 and holds until the next accepted start or reset.
- All outputs are registered; no combinational input-to-output path.
- Back-to-back runs: a `start` in the first cycle `done`=1 is accepted normally.

## Configuration
- `MULT_SEQ_CYCLE_COUNT_EN` defined:
  - `cycle_count` clears on accepted start and increments each cycle `busy`=1.
  - It holds its value after done or abort and saturates at 2^32−1.
- Not defined: counter logic is omitted; `cycle_count` is tied to 0 and the port is retained.

## Test plan
- N=4, L=3, start at T → `r_en` T+1..T+4, addrs 0,1,2,3; `we` T+4..T+7, same addrs; `done` at T+8; count=7 (macro on).
- N=0 → no `r_en`/`we`, `busy` stays 0, `done`=1 one cycle after start.
- N=512, L=16, ADDR_WIDTH=9 → 512 reads addr 0..511 with no wrap repeat; 512 writes; last `we` at T+528.
- L=0 → behaves as L=1; L=31 with MAX_LATENCY=16 → behaves as L=16.
- N=10, L=5, abort at T+6 → `r_en`/`we`/`busy` low at T+7, `done` stays 0; new start at T+8 with N=2 runs cleanly from addr 0.
- `start` pulsed at T+3 of an N=8 run → ignored, run completes unchanged. resetn low at T+5 → all outputs 0 immediately, FSM IDLE.
